// File: rtl/mult_nxn_seq_pkg.sv
// Shared types and helpers for the digit-serial N x N multiplier.
package mult_nxn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int unsigned calc_d(int unsigned n, int unsigned k);
    return n / k;
  endfunction

  // Digit index width, kept at least one bit so D=1 still has a legal register.
  function automatic int unsigned idx_w(int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/mult_kxk.sv
// Combinational K x K -> 2K unsigned partial-product multiplier.
module mult_kxk #(
  parameter int K = 2
) (
  input  logic [K-1:0]   x,
  input  logic [K-1:0]   y,
  output logic [2*K-1:0] p
);

  always_comb begin
    p = (2*K)'(x) * (2*K)'(y);
  end

endmodule

// File: rtl/mult_nxn_seq.sv
// Sequential N x N multiplier: sweeps D*D digit partial products into an
// accumulator, then applies the sign in a single FIX cycle.
module mult_nxn_seq
  import mult_nxn_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] out
);

  localparam int unsigned D  = calc_d(N, K);
  localparam int unsigned IW = idx_w(D);
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  state_e         state_q, state_d;
  logic [N:0]     ma_q, ma_d, mb_q, mb_d;
  logic           neg_q, neg_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] out_q, out_d;
  logic [IW-1:0]  i_q, i_d, j_q, j_d;

  logic [N:0]     a_ext, b_ext, a_mag, b_mag;
  logic [K-1:0]   dig_a, dig_b;
  logic [2*K-1:0] pp;
  logic [2*N-1:0] pp_sh, top_add, acc_fix;
  logic           sweep_end;

  // ---------------- control FSM ----------------
  assign sweep_end = (i_q == LAST) && (j_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (sweep_end) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign out  = out_q;

  // ---------------- datapath ----------------
  // Sign-extend into N+1 bits so that -2^(N-1) has an exact magnitude.
  always_comb begin
    a_ext = {sgn & a[N-1], a};
    b_ext = {sgn & b[N-1], b};
    a_mag = a_ext[N] ? -a_ext : a_ext;
    b_mag = b_ext[N] ? -b_ext : b_ext;
  end

  always_comb begin
    dig_a = ma_q[int'(i_q)*K +: K];
    dig_b = mb_q[int'(j_q)*K +: K];
  end

  mult_kxk #(.K(K)) u_pp (
    .x(dig_a),
    .y(dig_b),
    .p(pp)
  );

  always_comb begin
    pp_sh = (2*N)'(pp) << (K * (int'(i_q) + int'(j_q)));
    // Bit N of a magnitude lies above every digit; its cross terms are folded in at FIX.
    top_add = (ma_q[N] ? ((2*N)'(mb_q) << N) : '0)
            + (mb_q[N] ? ((2*N)'(ma_q) << N) : '0);
    acc_fix = acc_q + top_add;
  end

  always_comb begin
    ma_d  = ma_q;
    mb_d  = mb_q;
    neg_d = neg_q;
    acc_d = acc_q;
    out_d = out_q;
    i_d   = i_q;
    j_d   = j_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ma_d  = a_mag;
          mb_d  = b_mag;
          neg_d = sgn & (a[N-1] ^ b[N-1]);
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
        end
      end
      CALC: begin
        acc_d = acc_q + pp_sh;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = (i_q == LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      FIX: begin
        out_d = neg_q ? -acc_fix : acc_fix;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

endmodule

// File: tb/tb_mult_nxn_seq.sv
// Self-checking bench for mult_nxn_seq at N=4/K=2 and N=8/K=2.
module tb_mult_nxn_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start4, sgn4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  out4;
  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  int n_checks = 0;
  int n_fail   = 0;

  mult_nxn_seq #(.N(4), .K(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .out(out4)
  );

  mult_nxn_seq #(.N(8), .K(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .out(out8)
  );

  // Reference: true integer product of the interpreted operands, mod 2^(2n).
  function automatic longint ref_mul(int n, longint ua, longint ub, bit s);
    longint sa, sb, p;
    sa = (s && ua >= (longint'(1) << (n-1))) ? ua - (longint'(1) << n) : ua;
    sb = (s && ub >= (longint'(1) << (n-1))) ? ub - (longint'(1) << n) : ub;
    p  = sa * sb;
    return p & ((longint'(1) << (2*n)) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one N=4 operation; report result, edges to done (start edge = 1),
  // busy cycles seen and done-high cycles.
  task automatic run_op4(input logic [3:0] ia, input logic [3:0] ib, input bit is,
                         output logic [7:0] res, output int lat, output int bcnt,
                         output int dcnt);
    a4 = ia; b4 = ib; sgn4 = is; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    a4 = $urandom; b4 = $urandom; sgn4 = $urandom;
    lat = 1; bcnt = 0;
    while (!done4 && lat < 200) begin
      if (busy4) bcnt++;
      tick();
      lat++;
    end
    res = out4;
    dcnt = done4 ? 1 : 0;
    tick();
    if (done4) dcnt++;
  endtask

  task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input bit is,
                         output logic [15:0] res, output int lat);
    a8 = ia; b8 = ib; sgn8 = is; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 200) begin
      tick();
      lat++;
    end
    res = out8;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start4 = 1'b1; start8 = 1'b1;
    a4 = 4'd3; b4 = 4'd3; sgn4 = 1'b0; a8 = 8'd3; b8 = 8'd3; sgn8 = 1'b0;
    tick(); tick();
    n_checks++;
    if (out4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4: out=%h busy=%b done=%b required out=00 busy=0 done=0",
               out4, busy4, done4);
    end
    n_checks++;
    if (out8 !== 16'h0000 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: out=%h busy=%b done=%b required 0/0/0", out8, busy8, done8);
    end
    start4 = 1'b0; start8 = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_directed4();
    logic [3:0] ta [5] = '{4'd13, 4'b1101, 4'b1000, 4'd0,  4'd15};
    logic [3:0] tb [5] = '{4'd11, 4'd5,    4'b1000, 4'd15, 4'd15};
    bit         ts [5] = '{1'b0,  1'b1,    1'b1,    1'b0,  1'b0};
    logic [7:0] req [5] = '{8'h8F, 8'hF1, 8'h40, 8'h00, 8'hE1};
    logic [7:0] res;
    int lat, bcnt, dcnt;
    for (int t = 0; t < 5; t++) begin
      run_op4(ta[t], tb[t], ts[t], res, lat, bcnt, dcnt);
      n_checks++;
      if (res !== req[t]) begin
        n_fail++;
        $display("FAIL directed4[%0d] out: got %h required %h", t, res, req[t]);
      end
      n_checks++;
      if (lat != 6 || bcnt != 5 || dcnt != 1) begin
        n_fail++;
        $display("FAIL directed4[%0d] timing: lat=%0d busy=%0d done=%0d required 6/5/1",
                 t, lat, bcnt, dcnt);
      end
    end
  endtask

  task automatic test_random4();
    logic [3:0] ra, rb;
    bit rs;
    logic [7:0] res;
    int lat, bcnt, dcnt;
    for (int t = 0; t < 30; t++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
      run_op4(ra, rb, rs, res, lat, bcnt, dcnt);
      n_checks++;
      if (res !== 8'(ref_mul(4, longint'(ra), longint'(rb), rs)) || lat != 6) begin
        n_fail++;
        $display("FAIL random4 a=%h b=%h s=%b: got %h lat=%0d required %h lat=6",
                 ra, rb, rs, res, lat, 8'(ref_mul(4, longint'(ra), longint'(rb), rs)));
      end
    end
  endtask

  task automatic test_start_ignored();
    int pulses = 0;
    logic [7:0] res = '0;
    a4 = 4'd6; b4 = 4'd7; sgn4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a4 = 4'd1; b4 = 4'd1; sgn4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done4) begin
        pulses++;
        res = out4;
      end
      tick();
    end
    n_checks++;
    if (pulses != 1 || res !== 8'd42) begin
      n_fail++;
      $display("FAIL start_ignored: pulses=%0d out=%h required 1 pulse out=2a", pulses, res);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [7:0] res;
    int lat, bcnt, dcnt;
    a4 = 4'd9; b4 = 4'd9; sgn4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: out=%h busy=%b done=%b required 00/0/0", out4, busy4, done4);
    end
    for (int c = 0; c < 10; c++) begin
      if (done4) pulses++;
      tick();
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: pulses=%0d required 0", pulses);
    end
    run_op4(4'd2, 4'd3, 1'b0, res, lat, bcnt, dcnt);
    n_checks++;
    if (res !== 8'd6) begin
      n_fail++;
      $display("FAIL reset_mid_next: out=%h required 06", res);
    end
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    a4 = 4'd9; b4 = 4'd7; sgn4 = 1'b0; start4 = 1'b1;
    tick();
    while (!done4 && lat < 50) begin tick(); lat++; end
    n_checks++;
    if (out4 !== 8'd63 || !done4) begin
      n_fail++;
      $display("FAIL b2b_first: out=%h done=%b required 3f/1", out4, done4);
    end
    a4 = 4'd5; b4 = 4'd6;
    tick();
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || out4 !== 8'd63) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b done=%b out=%h required 0/0/3f", busy4, done4, out4);
    end
    tick();
    start4 = 1'b0;
    n_checks++;
    if (busy4 !== 1'b1 || out4 !== 8'd63) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b out=%h required 1/3f", busy4, out4);
    end
    lat = 1;
    while (!done4 && lat < 50) begin tick(); lat++; end
    n_checks++;
    if (out4 !== 8'd30 || lat != 6) begin
      n_fail++;
      $display("FAIL b2b_second: out=%h lat=%0d required 1e/6", out4, lat);
    end
    tick();
  endtask

  task automatic test_n8();
    logic [15:0] res;
    logic [7:0] ra, rb;
    bit rs;
    int lat;
    run_op8(8'd255, 8'd255, 1'b0, res, lat);
    n_checks++;
    if (res !== 16'hFE01 || lat != 18) begin
      n_fail++;
      $display("FAIL n8_max: out=%h lat=%0d required fe01/18", res, lat);
    end
    run_op8(8'h80, 8'h7F, 1'b1, res, lat);
    n_checks++;
    if (res !== 16'hC080 || lat != 18) begin
      n_fail++;
      $display("FAIL n8_signed: out=%h lat=%0d required c080/18", res, lat);
    end
    for (int t = 0; t < 12; t++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run_op8(ra, rb, rs, res, lat);
      n_checks++;
      if (res !== 16'(ref_mul(8, longint'(ra), longint'(rb), rs))) begin
        n_fail++;
        $display("FAIL n8_random a=%h b=%h s=%b: got %h required %h",
                 ra, rb, rs, res, 16'(ref_mul(8, longint'(ra), longint'(rb), rs)));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    sgn4 = 1'b0; sgn8 = 1'b0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    test_reset();
    test_directed4();
    test_random4();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_n8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
